ddr_burst_requester: RTL and testbench
======================================

Name: ddr_burst_requester

Overview:
- Client-side initiator for the ddr_sdram controller's external interface, i.e. the requester end of the BA_IN/ADDR_ROW_IN/ADDR_COL_IN/WRITE/READ/WRITE_LENGTH/BUSY/DATA_IN port.
- Accepts word-granular commands and 16-bit write words from a streaming host, packs them into one burst-wide bus, and issues a single WRITE or READ per command.
- For reads, it captures the returned burst and streams it back to the host one word at a time.

Parameters:
- BURST_LENGTH, 16: words per controller burst (2/4/8/16). Must match the controller setting.
- ADDR_WIDTH, 25: word address width, split as {bank[1:0], row[12:0], col[9:0]}.

Ports:
- SYS_CLK_100M  in  1  the only clock (same 100 MHz clock that feeds the controller)
- RST_N  in  1  synchronous active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY
- CMD_WRITE  in  1  1=write, 0=read
- CMD_ADDR  in  ADDR_WIDTH  start word address
- CMD_LEN  in  5  words 1..BURST_LENGTH; writes only; ignored for reads (reads always return a full burst)
- WDATA_VALID  in  1  write word valid
- WDATA  in  16  write word
- WDATA_READY  out  1  write word accepted
- RDATA_VALID  out  1  read word valid
- RDATA  out  16  read word
- RDATA_READY  in  1  host accepts read word
- BA_IN  out  2  to controller
- ADDR_ROW_IN  out  13  to controller
- ADDR_COL_IN  out  10  to controller
- WRITE  out  1  to controller
- READ  out  1  to controller
- WRITE_LENGTH  out  4  to controller
- BUSY  in  1  from controller
- DATA_IN  inout  16*BURST_LENGTH  controller burst bus; driven only in write states, Z otherwise

Behaviour:
- Reset (RST_N=0 at clock edge):
  - state IDLE; CMD_READY=0, WDATA_READY=0, RDATA_VALID=0, RDATA=0.
  - WRITE=0, READ=0, BA_IN=0, ADDR_ROW_IN=0, ADDR_COL_IN=0, WRITE_LENGTH=0.
  - DATA_IN released (Z); word counters 0; burst buffer contents don't-care.
  - Reset mid-operation aborts immediately with the same values. An in-flight controller burst is abandoned; the block does not wait for BUSY.
- Address split (registered at command accept): BA_IN=CMD_ADDR[24:23], ADDR_ROW_IN=CMD_ADDR[22:10], ADDR_COL_IN=CMD_ADDR[9:0]. No alignment is enforced.
- WRITE_LENGTH = CMD_LEN[3:0]. CMD_LEN=16 therefore encodes 0, which the interface defines as a full, unmasked burst. CMD_LEN=0 or >BURST_LENGTH is clamped to BURST_LENGTH.
- States:
  - IDLE: CMD_READY=1 only when BUSY=0. On accept: write goes to FILL; read goes to ISSUE.
  - FILL: WDATA_READY=1. Each accepted word goes to buffer[wcnt], wcnt++. After CMD_LEN words, go to ISSUE. Unfilled slots are written 16'h0000.
  - ISSUE: assert WRITE (or READ); DATA_IN driven with the packed buffer, word 0 in bits [15:0]. Hold until BUSY=1 is sampled, then deassert WRITE/READ (1-cycle turnaround) and go to WAIT.
  - WAIT: hold BA/ROW/COL/WRITE_LENGTH and the DATA_IN drive (writes) stable. On the first cycle BUSY=0: writes return to IDLE; reads capture DATA_IN into the buffer and go to DRAIN.
  - DRAIN: RDATA=buffer[rcnt], RDATA_VALID=1. Advance rcnt on RDATA_VALID && RDATA_READY. After word BURST_LENGTH-1 is accepted, return to IDLE.
- Handshakes are AXI-style: VALID must not depend on READY; RDATA is held stable while RDATA_VALID && !RDATA_READY.
- Latency, write: command accept to WRITE high = CMD_LEN+1 cycles when WDATA streams back-to-back.
- Latency, read: first RDATA_VALID = 1 cycle after BUSY falls.
- CMD_READY=0 in every non-IDLE state: no overlapping commands.
- BUSY already high in IDLE (controller still initialising): no command is accepted.
- BUSY never rising in ISSUE: WRITE/READ stays asserted indefinitely, unless the optional timeout below is compiled in.

Optional Feature:
- Macro: DDR_REQ_TIMEOUT_EN.
- Enabled:
  - Adds a 10-bit watchdog, cleared on entry to ISSUE and to WAIT.
  - If it reaches 1023 in ISSUE or WAIT, the block deasserts WRITE/READ, releases DATA_IN, pulses output ERR_TIMEOUT for 1 cycle, and returns to IDLE. No RDATA is produced.
- Disabled: no counter and no ERR_TIMEOUT port; the block waits forever.

Decomposition:
- Package ddr_pkg:
  - state encoding (IDLE/FILL/ISSUE/WAIT/DRAIN);
  - address field widths and offsets (BANK_W=2, ROW_W=13, COL_W=10);
  - default BURST_LENGTH;
  - timeout limit.
- Sub-module ddr_burst_buf: BURST_LENGTH x 16 register file with indexed write, indexed read, and flat parallel load/unload to the burst bus.

Test Plan:
- Full write: CMD_ADDR={2'b10,13'h0123,10'h040}, CMD_LEN=16, words 16'h1000..16'h100F back-to-back -> BA_IN=2, ADDR_ROW_IN=0x123, ADDR_COL_IN=0x040, WRITE_LENGTH=0, DATA_IN[15:0]=0x1000 and [255:240]=0x100F; WRITE drops the cycle after BUSY rises.
- Partial write: CMD_LEN=3, words 0xAAAA/0xBBBB/0xCCCC -> WRITE_LENGTH=3; DATA_IN slots 3..15 = 0x0000.
- Read with backpressure: controller model returns a burst of 16'h2000+i; RDATA_READY toggles every cycle -> 16 words 0x2000..0x200F in order, each held stable until accepted.
- BUSY high out of reset: CMD_VALID=1 for 50 cycles -> CMD_READY=0 throughout; accepted the cycle after BUSY falls.
- Reset in WAIT of a write -> next edge: WRITE=0, DATA_IN=Z, CMD_READY=0; IDLE resumes once RST_N=1.
- With DDR_REQ_TIMEOUT_EN, BUSY held 0 after read issue -> after 1023 cycles READ=0, ERR_TIMEOUT pulses once, RDATA_VALID stays 0.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared state encoding, address geometry and length helper for ddr_burst_requester.
package ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 5;

  localparam int BANK_W   = 2;
  localparam int ROW_W    = 13;
  localparam int COL_W    = 10;
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = COL_LSB + COL_W;
  localparam int BANK_LSB = ROW_LSB + ROW_W;

  localparam int DEF_BURST_LENGTH = 16;

  localparam int                WDOG_W        = 10;
  localparam logic [WDOG_W-1:0] TIMEOUT_LIMIT = '1;

  // Zero or oversize lengths mean "whole burst".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int burst_length);
    logic [LEN_W-1:0] bl;
    bl = LEN_W'(burst_length);
    return ((len == '0) || (len > bl)) ? bl : len;
  endfunction

endpackage

// File: rtl/ddr_burst_buf.sv
// Burst staging buffer: one 16-bit register per burst slot, with indexed
// write/read and whole-burst parallel load and flat unload.
module ddr_burst_buf
  import ddr_pkg::*;
#(
  parameter int BURST_LENGTH = DEF_BURST_LENGTH,
  parameter int IDX_W        = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1
) (
  input  logic                           SYS_CLK_100M,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [WORD_W-1:0]              wr_data,
  input  logic                           load_en,
  input  logic [WORD_W*BURST_LENGTH-1:0] load_data,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [WORD_W-1:0]              rd_data,
  output logic [WORD_W*BURST_LENGTH-1:0] flat_data
);

  for (genvar gi = 0; gi < BURST_LENGTH; gi++) begin : g_word
    logic [WORD_W-1:0] word_reg;

    // A parallel load wins over a single-word write in the same cycle.
    always_ff @(posedge SYS_CLK_100M) begin
      if (load_en) begin
        word_reg <= load_data[gi*WORD_W +: WORD_W];
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign flat_data[gi*WORD_W +: WORD_W] = word_reg;
  end

  assign rd_data = flat_data[rd_idx*WORD_W +: WORD_W];

endmodule

// File: rtl/ddr_burst_requester.sv
// Host-side requester for the ddr_sdram controller: packs word writes into one
// burst, unpacks read bursts. Optional watchdog: define DDR_REQ_TIMEOUT_EN.
module ddr_burst_requester
  import ddr_pkg::*;
#(
  parameter int BURST_LENGTH = DEF_BURST_LENGTH,
  parameter int ADDR_WIDTH   = 25
) (
  input  logic                           SYS_CLK_100M,
  input  logic                           RST_N,
  input  logic                           CMD_VALID,
  output logic                           CMD_READY,
  input  logic                           CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]          CMD_ADDR,
  input  logic [LEN_W-1:0]               CMD_LEN,
  input  logic                           WDATA_VALID,
  input  logic [WORD_W-1:0]              WDATA,
  output logic                           WDATA_READY,
  output logic                           RDATA_VALID,
  output logic [WORD_W-1:0]              RDATA,
  input  logic                           RDATA_READY,
  output logic [BANK_W-1:0]              BA_IN,
  output logic [ROW_W-1:0]               ADDR_ROW_IN,
  output logic [COL_W-1:0]               ADDR_COL_IN,
  output logic                           WRITE,
  output logic                           READ,
  output logic [3:0]                     WRITE_LENGTH,
  input  logic                           BUSY,
  inout  wire  [WORD_W*BURST_LENGTH-1:0] DATA_IN
`ifdef DDR_REQ_TIMEOUT_EN
  ,
  output logic                           ERR_TIMEOUT
`endif
);

  localparam int IDX_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam int BUS_W = WORD_W * BURST_LENGTH;

  state_t            state_reg, state_next;
  logic              is_write_reg;
  logic [LEN_W-1:0]  len_reg, wcnt_reg, len_sel;
  logic [IDX_W-1:0]  rcnt_reg;
  logic [BANK_W-1:0] ba_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [COL_W-1:0]  col_reg;
  logic [3:0]        wlen_reg;

  logic              cmd_fire, wdata_fire, rdata_fire, last_word, rd_last;
  logic              drive_bus, capture, timeout, buf_load;
  logic [WORD_W-1:0] buf_rd;
  logic [BUS_W-1:0]  buf_flat, buf_load_data;

  assign cmd_fire   = CMD_VALID && CMD_READY;
  assign wdata_fire = WDATA_VALID && WDATA_READY;
  assign rdata_fire = RDATA_VALID && RDATA_READY;
  assign last_word  = (wcnt_reg + LEN_W'(1)) == len_reg;
  assign rd_last    = rcnt_reg == IDX_W'(BURST_LENGTH - 1);
  assign len_sel    = CMD_WRITE ? clamp_len(CMD_LEN, BURST_LENGTH) : LEN_W'(BURST_LENGTH);

`ifdef DDR_REQ_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_reg;

  assign timeout     = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) &&
                       (wdog_reg == TIMEOUT_LIMIT);
  assign ERR_TIMEOUT = timeout;

  // Restarts on every state change, so ISSUE and WAIT each get a full window.
  always_ff @(posedge SYS_CLK_100M) begin
    if (!RST_N || (state_next != state_reg)) begin
      wdog_reg <= '0;
    end else if ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) begin
      wdog_reg <= wdog_reg + WDOG_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    CMD_READY   = 1'b0;
    WDATA_READY = 1'b0;
    RDATA_VALID = 1'b0;
    WRITE       = 1'b0;
    READ        = 1'b0;
    drive_bus   = 1'b0;
    capture     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        // Held low through reset so nothing is accepted while RST_N is asserted.
        CMD_READY = !BUSY && RST_N;
        if (cmd_fire) state_next = CMD_WRITE ? ST_FILL : ST_ISSUE;
      end
      ST_FILL: begin
        WDATA_READY = 1'b1;
        if (wdata_fire && last_word) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        WRITE     = is_write_reg && !timeout;
        READ      = !is_write_reg && !timeout;
        drive_bus = is_write_reg && !timeout;
        if (timeout)   state_next = ST_IDLE;
        else if (BUSY) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        drive_bus = is_write_reg && !timeout;
        capture   = !BUSY && !is_write_reg && !timeout;
        if (timeout)    state_next = ST_IDLE;
        else if (!BUSY) state_next = is_write_reg ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        RDATA_VALID = 1'b1;
        if (rdata_fire && rd_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_100M) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      is_write_reg <= 1'b0;
      len_reg      <= '0;
      wcnt_reg     <= '0;
      rcnt_reg     <= '0;
      ba_reg       <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      wlen_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (cmd_fire) begin
        is_write_reg <= CMD_WRITE;
        len_reg      <= len_sel;
        wlen_reg     <= len_sel[3:0];
        ba_reg       <= CMD_ADDR[BANK_LSB +: BANK_W];
        row_reg      <= CMD_ADDR[ROW_LSB +: ROW_W];
        col_reg      <= CMD_ADDR[COL_LSB +: COL_W];
        wcnt_reg     <= '0;
        rcnt_reg     <= '0;
      end
      if (wdata_fire) wcnt_reg <= wcnt_reg + LEN_W'(1);
      if (rdata_fire) rcnt_reg <= rcnt_reg + IDX_W'(1);
    end
  end

  // Clearing on write accept leaves slots past CMD_LEN as zero.
  assign buf_load      = (cmd_fire && CMD_WRITE) || capture;
  assign buf_load_data = capture ? DATA_IN : '0;

  ddr_burst_buf #(
    .BURST_LENGTH(BURST_LENGTH),
    .IDX_W       (IDX_W)
  ) u_buf (
    .SYS_CLK_100M(SYS_CLK_100M),
    .wr_en       (wdata_fire),
    .wr_idx      (wcnt_reg[IDX_W-1:0]),
    .wr_data     (WDATA),
    .load_en     (buf_load),
    .load_data   (buf_load_data),
    .rd_idx      (rcnt_reg),
    .rd_data     (buf_rd),
    .flat_data   (buf_flat)
  );

  assign RDATA        = RDATA_VALID ? buf_rd : '0;
  assign DATA_IN      = drive_bus ? buf_flat : {BUS_W{1'bz}};
  assign BA_IN        = ba_reg;
  assign ADDR_ROW_IN  = row_reg;
  assign ADDR_COL_IN  = col_reg;
  assign WRITE_LENGTH = wlen_reg;

endmodule

// File: tb/tb_ddr_burst_requester.sv
// Directed self-checking bench for ddr_burst_requester; the bench plays both
// the streaming host and the ddr_sdram controller. Timeout test needs DDR_REQ_TIMEOUT_EN.
module tb_ddr_burst_requester;

  localparam int BL    = 16;
  localparam int BUS_W = 16 * BL;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_write = 1'b0;
  logic [24:0]       cmd_addr = '0;
  logic [4:0]        cmd_len = '0;
  logic              wdata_valid = 1'b0;
  logic [15:0]       wdata = '0;
  logic              rdata_ready = 1'b0;
  logic              busy = 1'b0;
  logic              cmd_ready, wdata_ready, rdata_valid, write, read;
  logic [15:0]       rdata;
  logic [1:0]        ba;
  logic [12:0]       row;
  logic [9:0]        col;
  logic [3:0]        wlen;
  wire  [BUS_W-1:0]  data_bus;
  logic              tb_drive = 1'b0;
  logic [BUS_W-1:0]  tb_data = '0;
`ifdef DDR_REQ_TIMEOUT_EN
  logic              err_timeout;
`endif

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  assign data_bus = tb_drive ? tb_data : {BUS_W{1'bz}};

  ddr_burst_requester #(
    .BURST_LENGTH(BL),
    .ADDR_WIDTH  (25)
  ) dut (
    .SYS_CLK_100M(sys_clk),
    .RST_N       (rst_n),
    .CMD_VALID   (cmd_valid),
    .CMD_READY   (cmd_ready),
    .CMD_WRITE   (cmd_write),
    .CMD_ADDR    (cmd_addr),
    .CMD_LEN     (cmd_len),
    .WDATA_VALID (wdata_valid),
    .WDATA       (wdata),
    .WDATA_READY (wdata_ready),
    .RDATA_VALID (rdata_valid),
    .RDATA       (rdata),
    .RDATA_READY (rdata_ready),
    .BA_IN       (ba),
    .ADDR_ROW_IN (row),
    .ADDR_COL_IN (col),
    .WRITE       (write),
    .READ        (read),
    .WRITE_LENGTH(wlen),
    .BUSY        (busy),
    .DATA_IN     (data_bus)
`ifdef DDR_REQ_TIMEOUT_EN
    ,
    .ERR_TIMEOUT (err_timeout)
`endif
  );

  // Drives zeros onto the bus briefly; a released DUT leaves the bus at zero.
  task automatic bus_probe(output logic [BUS_W-1:0] v);
    tb_data  = '0;
    tb_drive = 1'b1;
    #1;
    v        = data_bus;
    tb_drive = 1'b0;
  endtask

  // Streams n words; returns clock cycles spent. Starts and ends #1 after a posedge.
  task automatic send_words(input logic [15:0] words [16], input int n, output int cycles);
    int i;
    i = 0;
    cycles = 0;
    wdata_valid = 1'b1;
    while (i < n && cycles < 100) begin
      wdata = words[i];
      @(negedge sys_clk);
      if (wdata_ready) i++;
      @(posedge sys_clk); #1;
      cycles++;
    end
    wdata_valid = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL wdata_accept: accepted %0d words, expected %0d", i, n);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [24:0] addr, input logic [4:0] len);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Controller acknowledges an issued write: BUSY for one cycle, then idle.
  task automatic ack_write();
    busy = 1'b1;
    @(posedge sys_clk); #1;
    busy = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    logic [BUS_W-1:0] v;
    rst_n = 1'b0;
    busy  = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if ({write, read} !== 2'b00) begin errors++; $display("FAIL rst_wr_rd: got %b want 00", {write, read}); end
    checks++; if ({ba, row, col, wlen} !== 29'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", {ba, row, col, wlen}); end
    checks++; if ({rdata_valid, rdata, wdata_ready} !== 18'd0) begin errors++; $display("FAIL rst_data_hs: got %h want 0", {rdata_valid, rdata, wdata_ready}); end
    bus_probe(v);
    checks++; if (v !== '0) begin errors++; $display("FAIL rst_bus_release: got %h want 0", v); end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_exit_ready: got %b want 1", cmd_ready); end
    @(posedge sys_clk); #1;
    $display("reset: done");
  endtask

  task automatic test_full_write();
    logic [15:0] w [16];
    logic [BUS_W-1:0] exp, v;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      w[i] = 16'h1000 + 16'(i);
      exp[i*16 +: 16] = w[i];
    end
    issue_cmd(1'b1, {2'b10, 13'h0123, 10'h040}, 5'd16);
    send_words(w, 16, cyc);
    @(negedge sys_clk);
    checks++; if (cyc != 16) begin errors++; $display("FAIL full_latency: got %0d fill cycles want 16", cyc); end
    checks++; if ({write, read} !== 2'b10) begin errors++; $display("FAIL full_write_hi: got %b want 10", {write, read}); end
    checks++; if ({ba, row, col} !== {2'd2, 13'h0123, 10'h040}) begin errors++; $display("FAIL full_addr: got %h want %h", {ba, row, col}, {2'd2, 13'h0123, 10'h040}); end
    checks++; if (wlen !== 4'd0) begin errors++; $display("FAIL full_wlen: got %0d want 0", wlen); end
    checks++; if (data_bus !== exp) begin errors++; $display("FAIL full_bus: got %h want %h", data_bus, exp); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_no_overlap: got %b want 0", cmd_ready); end
    @(posedge sys_clk); #1;
    busy = 1'b1;
    @(negedge sys_clk);
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL full_write_hold: got %b want 1", write); end
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL full_write_drop: got %b want 0", write); end
    checks++; if (data_bus !== exp) begin errors++; $display("FAIL full_bus_wait: got %h want %h", data_bus, exp); end
    @(posedge sys_clk); #1;
    busy = 1'b0;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_back_idle: got %b want 1", cmd_ready); end
    bus_probe(v);
    checks++; if (v !== '0) begin errors++; $display("FAIL full_bus_release: got %h want 0", v); end
    @(posedge sys_clk); #1;
    $display("write: addr=%h len=16 done", {2'b10, 13'h0123, 10'h040});
  endtask

  task automatic test_partial_write();
    logic [15:0] w [16];
    logic [BUS_W-1:0] exp;
    int cyc;
    for (int i = 0; i < 16; i++) w[i] = 16'h0;
    w[0] = 16'hAAAA; w[1] = 16'hBBBB; w[2] = 16'hCCCC;
    exp = '0;
    exp[47:0] = 48'hCCCC_BBBB_AAAA;
    issue_cmd(1'b1, {2'b01, 13'h1ABC, 10'h3FF}, 5'd3);
    send_words(w, 3, cyc);
    @(negedge sys_clk);
    checks++; if (cyc != 3) begin errors++; $display("FAIL part_latency: got %0d fill cycles want 3", cyc); end
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL part_write_hi: got %b want 1", write); end
    checks++; if (wlen !== 4'd3) begin errors++; $display("FAIL part_wlen: got %0d want 3", wlen); end
    checks++; if (data_bus !== exp) begin errors++; $display("FAIL part_bus: got %h want %h", data_bus, exp); end
    @(posedge sys_clk); #1;
    ack_write();
    $display("write: addr=%h len=3 done", {2'b01, 13'h1ABC, 10'h3FF});
  endtask

  task automatic test_len_clamp();
    logic [15:0] w [16];
    int cyc;
    for (int i = 0; i < 16; i++) w[i] = 16'h3000 + 16'(i);
    issue_cmd(1'b1, 25'h0, 5'd0);
    send_words(w, 16, cyc);
    @(negedge sys_clk);
    checks++; if (cyc != 16) begin errors++; $display("FAIL clamp_words: got %0d fill cycles want 16", cyc); end
    checks++; if ({write, wlen} !== 5'b1_0000) begin errors++; $display("FAIL clamp_wlen: got write=%b wlen=%0d want 1/0", write, wlen); end
    @(posedge sys_clk); #1;
    ack_write();
    $display("write: addr=0 len=0 (full burst) done");
  endtask

  task automatic test_read_backpressure();
    logic [BUS_W-1:0] v;
    int k;
    logic accepted;
    issue_cmd(1'b0, {2'b11, 13'h0007, 10'h010}, 5'd3);
    @(negedge sys_clk);
    checks++; if ({write, read} !== 2'b01) begin errors++; $display("FAIL rd_issue: got %b want 01", {write, read}); end
    checks++; if ({ba, row, col} !== {2'd3, 13'h0007, 10'h010}) begin errors++; $display("FAIL rd_addr: got %h want %h", {ba, row, col}, {2'd3, 13'h0007, 10'h010}); end
    bus_probe(v);
    checks++; if (v !== '0) begin errors++; $display("FAIL rd_bus_release: got %h want 0", v); end
    @(posedge sys_clk); #1;
    busy = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 16; i++) tb_data[i*16 +: 16] = 16'h2000 + 16'(i);
    tb_drive = 1'b1;
    @(negedge sys_clk);
    checks++; if ({read, rdata_valid} !== 2'b00) begin errors++; $display("FAIL rd_wait: got %b want 00", {read, rdata_valid}); end
    @(posedge sys_clk); #1;
    busy = 1'b0;
    @(negedge sys_clk);
    checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b want 0", rdata_valid); end
    @(posedge sys_clk); #1;
    tb_drive = 1'b0;
    k = 0;
    rdata_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
      @(negedge sys_clk);
      checks++;
      if (rdata_valid !== 1'b1) begin
        errors++; $display("FAIL rd_valid: word %0d got valid=%b want 1", k, rdata_valid);
      end else if (rdata !== 16'h2000 + 16'(k)) begin
        errors++; $display("FAIL rd_data: word %0d got %h want %h", k, rdata, 16'h2000 + 16'(k));
      end
      accepted = rdata_ready;
      @(posedge sys_clk); #1;
      if (accepted) k++;
      rdata_ready = ~rdata_ready;
    end
    rdata_ready = 1'b0;
    checks++; if (k != 16) begin errors++; $display("FAIL rd_count: got %0d words want 16", k); end
    @(negedge sys_clk);
    checks++; if ({rdata_valid, rdata, cmd_ready} !== 18'd1) begin errors++; $display("FAIL rd_end: got valid=%b data=%h ready=%b want 0/0/1", rdata_valid, rdata, cmd_ready); end
    @(posedge sys_clk); #1;
    $display("read: addr=%h 16 words drained", {2'b11, 13'h0007, 10'h010});
  endtask

  task automatic test_busy_after_reset();
    logic [15:0] w [16];
    int cyc;
    int bad;
    for (int i = 0; i < 16; i++) w[i] = 16'h0;
    w[0] = 16'h5555;
    rst_n = 1'b0;
    busy  = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 25'h0AA_5555;
    cmd_len   = 5'd1;
    cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (cmd_ready !== 1'b0 || wdata_ready !== 1'b0) bad++;
      @(posedge sys_clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_block: %0d cycles with ready high, want 0", bad); end
    busy = 1'b0;
    @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_release_ready: got %b want 1", cmd_ready); end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    checks++; if (wdata_ready !== 1'b1) begin errors++; $display("FAIL busy_accept: got %b want 1", wdata_ready); end
    @(posedge sys_clk); #1;
    send_words(w, 1, cyc);
    busy = 1'b1;
    @(posedge sys_clk); #1;
    $display("busy-at-reset: command accepted after BUSY fell");
  endtask

  // Entered with a one-word write (0x5555) parked in WAIT.
  task automatic test_reset_in_wait();
    logic [BUS_W-1:0] v;
    @(negedge sys_clk);
    checks++; if (data_bus[15:0] !== 16'h5555) begin errors++; $display("FAIL wait_bus: got %h want 5555", data_bus[15:0]); end
    @(posedge sys_clk); #1;
    rst_n = 1'b0;
    busy  = 1'b0;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    checks++; if ({write, cmd_ready, wdata_ready} !== 3'b000) begin errors++; $display("FAIL rstw_outputs: got %b want 000", {write, cmd_ready, wdata_ready}); end
    bus_probe(v);
    checks++; if (v !== '0) begin errors++; $display("FAIL rstw_bus_release: got %h want 0", v); end
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(negedge sys_clk);
    checks++; if ({cmd_ready, wdata_ready} !== 2'b10) begin errors++; $display("FAIL rstw_idle: got %b want 10", {cmd_ready, wdata_ready}); end
    @(posedge sys_clk); #1;
    $display("reset-in-wait: aborted, idle again");
  endtask

`ifdef DDR_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int err_cyc, pulses;
    logic saw_rvalid, read_before;
    err_cyc = -1; pulses = 0; saw_rvalid = 1'b0; read_before = 1'b0;
    busy = 1'b0;
    issue_cmd(1'b0, 25'h1234, 5'd16);
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge sys_clk);
      if (err_timeout === 1'b1) begin
        pulses++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (rdata_valid !== 1'b0) saw_rvalid = 1'b1;
      if (cyc == 1022) read_before = read;
      @(posedge sys_clk); #1;
    end
    @(negedge sys_clk);
    checks++; if (read_before !== 1'b1) begin errors++; $display("FAIL to_read_held: got %b want 1", read_before); end
    checks++; if (err_cyc != 1023) begin errors++; $display("FAIL to_cycle: got %0d want 1023", err_cyc); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", pulses); end
    checks++; if ({read, saw_rvalid, cmd_ready} !== 3'b001) begin errors++; $display("FAIL to_end: got %b want 001", {read, saw_rvalid, cmd_ready}); end
    @(posedge sys_clk); #1;
    $display("timeout: read abandoned after watchdog");
  endtask
`endif

  initial begin
    #500us;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_len_clamp();
    test_read_backpressure();
    test_busy_after_reset();
    test_reset_in_wait();
`ifdef DDR_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
